// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the bit-serial BCD adder.
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StCorr,
    StFin
  } state_e;

  localparam int unsigned BcdDigitW = 4;
  localparam logic [3:0]  BcdMax    = 4'd9;
  localparam logic [3:0]  BcdCorr   = 4'd6;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BcdMax;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_full_adder.sv
// Single-bit full-adder cell used as the serial adder core.
module bcd_serial_adder_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/bcd_serial_adder.sv
// Bit-serial multi-digit BCD adder: one full-adder bit per clock, one +6 correction
// cycle per digit, result registered alongside a one-cycle DONE pulse.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  CIN,
  output logic [4*DIGITS-1:0]   S,
  output logic                  COUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned W       = BcdDigitW * DIGITS;
  localparam int unsigned DigCntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BitCntW = $clog2(BcdDigitW);

  state_e               state_q, state_d;
  logic [W-1:0]         a_sh_q, a_sh_d;
  logic [W-1:0]         b_sh_q, b_sh_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [3:0]           dig_q, dig_d;
  logic                 carry_q, carry_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DigCntW-1:0]   dig_cnt_q, dig_cnt_d;
  logic                 err_cap_q, err_cap_d;
  logic [W-1:0]         s_q, s_d;
  logic                 cout_q, cout_d;
  logic                 err_q, err_d;

  logic                 fa_sum, fa_cout;
  logic                 in_err;
  logic [4:0]           z, z_corr;
  logic                 z_big;
  logic [3:0]           corr_digit;

  bcd_serial_adder_full_adder u_full_adder (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      in_err = in_err | digit_invalid(A[i*BcdDigitW +: BcdDigitW])
                      | digit_invalid(B[i*BcdDigitW +: BcdDigitW]);
    end
  end

  assign z          = {carry_q, dig_q};
  assign z_big      = z > {1'b0, BcdMax};
  assign z_corr     = z + {1'b0, BcdCorr};
  assign corr_digit = z_big ? z_corr[3:0] : z[3:0];

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    dig_d     = dig_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    dig_cnt_d = dig_cnt_q;
    err_cap_d = err_cap_q;
    s_d       = s_q;
    cout_d    = cout_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          a_sh_d    = A;
          b_sh_d    = B;
          carry_d   = CIN;
          bit_cnt_d = '0;
          dig_cnt_d = '0;
          dig_d     = '0;
          acc_d     = '0;
          err_cap_d = in_err;
          state_d   = StAdd;
        end
      end
      StAdd: begin
        // LSB-first: after four shifts bit 0 of the digit lands in dig_q[0]
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        dig_d     = {fa_sum, dig_q[3:1]};
        carry_d   = fa_cout;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BitCntW'(BcdDigitW - 1)) begin
          state_d = StCorr;
        end
      end
      StCorr: begin
        acc_d   = (acc_q >> BcdDigitW) | (W'(corr_digit) << (W - BcdDigitW));
        carry_d = z_big;
        if (dig_cnt_q == DigCntW'(DIGITS - 1)) begin
          // Result registers load on entry to FIN so they are valid with DONE
          s_d     = acc_d;
          cout_d  = z_big;
          err_d   = err_cap_q;
          state_d = StFin;
        end else begin
          dig_cnt_d = dig_cnt_q + 1'b1;
          state_d   = StAdd;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      dig_q     <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      dig_cnt_q <= '0;
      err_cap_q <= 1'b0;
      s_q       <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      acc_q     <= acc_d;
      dig_q     <= dig_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
      dig_cnt_q <= dig_cnt_d;
      err_cap_q <= err_cap_d;
      s_q       <= s_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign ERR  = err_q;
  assign BUSY = (state_q == StAdd) || (state_q == StCorr);
  assign DONE = (state_q == StFin);

endmodule
